// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// flags, protected pointers, sticky overflow/underflow flags, synchronous flush
// and an optional first-word-fall-through read port.
//
// Storage is a DEPTH-entry register array read combinationally. In standard
// mode the popped word is captured into rdata on the read edge. In FWFT mode
// rdata/rvalid form a one-word output stage holding the head of the queue; the
// array only holds the words behind it. A write into an FWFT FIFO whose array
// is empty and whose output stage is free (or being freed) bypasses the array
// straight into the output stage, so the word is presented right after its
// write edge.
module fifo_sync_flags #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH_WIDTH  = 5,
  parameter int AFULL_LEVEL  = (2 ** DEPTH_WIDTH) - 2,
  parameter int AEMPTY_LEVEL = 1,
  parameter bit FWFT         = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wreq,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wfull,
  output logic                  almost_full,
  input  logic                  rreq,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  rempty,
  output logic                  almost_empty,
  output logic [DEPTH_WIDTH:0]  level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int DEPTH = 2 ** DEPTH_WIDTH;
  localparam int LVL_W = DEPTH_WIDTH + 1;

  localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_AFULL  = LVL_W'(AFULL_LEVEL);
  localparam logic [LVL_W-1:0] LVL_AEMPTY = LVL_W'(AEMPTY_LEVEL);
  localparam logic [LVL_W-1:0] LVL_ONE    = LVL_W'(1);

  // Sticky flag update: a new event in the clear cycle keeps the flag set.
  function automatic logic sticky_next(input logic cur, input logic set,
                                       input logic clr);
    return set | (cur & ~clr);
  endfunction

  // Pointer advance by one entry; the extra MSB is the wrap segment bit.
  function automatic logic [DEPTH_WIDTH:0] ptr_inc(input logic [DEPTH_WIDTH:0] p,
                                                   input logic en);
    return en ? (p + {{DEPTH_WIDTH{1'b0}}, 1'b1}) : p;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DEPTH_WIDTH:0]  wptr;
  logic [DEPTH_WIDTH:0]  rptr;
  logic [DEPTH_WIDTH:0]  wptr_nxt;
  logic [DEPTH_WIDTH:0]  rptr_nxt;
  logic [DEPTH_WIDTH:0]  ram_cnt;
  logic [LVL_W-1:0]      level_nxt;
  logic [DATA_WIDTH-1:0] rdata_nxt;
  logic                  rvalid_nxt;
  logic                  rempty_nxt;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  ram_we;
  logic                  ram_rd;
  logic                  ovf_evt;
  logic                  unf_evt;

  // Acceptance, storage routing and next-state computation.
  always_comb begin
    wr_ok      = wreq & ~wfull & ~flush;
    rd_ok      = rreq & ~rempty & ~flush;
    ovf_evt    = wreq & wfull & ~flush;
    unf_evt    = rreq & rempty & ~flush;
    ram_cnt    = wptr - rptr;
    ram_we     = 1'b0;
    ram_rd     = 1'b0;
    rdata_nxt  = rdata;
    rvalid_nxt = 1'b0;

    level_nxt = level;
    if (wr_ok && !rd_ok) begin
      level_nxt = level + LVL_ONE;
    end else if (rd_ok && !wr_ok) begin
      level_nxt = level - LVL_ONE;
    end

    if (FWFT) begin
      // rvalid doubles as the "output stage occupied" bit.
      if (!rvalid || rd_ok) begin
        if (ram_cnt != '0) begin
          ram_rd     = 1'b1;
          rdata_nxt  = mem[rptr[DEPTH_WIDTH-1:0]];
          rvalid_nxt = 1'b1;
          ram_we     = wr_ok;
        end else if (wr_ok) begin
          rdata_nxt  = wdata;
          rvalid_nxt = 1'b1;
        end
      end else begin
        rvalid_nxt = 1'b1;
        ram_we     = wr_ok;
      end
    end else begin
      ram_we = wr_ok;
      ram_rd = rd_ok;
      if (rd_ok) begin
        rdata_nxt  = mem[rptr[DEPTH_WIDTH-1:0]];
        rvalid_nxt = 1'b1;
      end
    end

    wptr_nxt = ptr_inc(wptr, ram_we);
    rptr_nxt = ptr_inc(rptr, ram_rd);

    // Flush wins over any request in the same cycle; rdata keeps its value.
    if (flush) begin
      level_nxt  = '0;
      wptr_nxt   = '0;
      rptr_nxt   = '0;
      rvalid_nxt = 1'b0;
      rdata_nxt  = rdata;
    end

    rempty_nxt = FWFT ? ~rvalid_nxt : (level_nxt == '0);
  end

  // Data array write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[wptr[DEPTH_WIDTH-1:0]] <= wdata;
    end
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      level        <= '0;
      wfull        <= 1'b0;
      rempty       <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wptr         <= wptr_nxt;
      rptr         <= rptr_nxt;
      level        <= level_nxt;
      wfull        <= (level_nxt == LVL_FULL);
      rempty       <= rempty_nxt;
      almost_full  <= (level_nxt >= LVL_AFULL);
      almost_empty <= (level_nxt <= LVL_AEMPTY);
    end
  end

  // Read port: captured head word and its valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rdata  <= rdata_nxt;
      rvalid <= rvalid_nxt;
    end
  end

  // Sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= sticky_next(overflow, ovf_evt, clr_err);
      underflow <= sticky_next(underflow, unf_evt, clr_err);
    end
  end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench for fifo_sync_flags: one standard-mode and one FWFT instance,
// both DEPTH=4, AFULL_LEVEL=3, AEMPTY_LEVEL=1.
module tb_fifo_sync_flags;

  logic       clk = 1'b0;
  logic       rst;

  logic       flush, wreq, rreq, clr_err;
  logic [7:0] wdata;
  logic       wfull, almost_full, rvalid, rempty, almost_empty, overflow, underflow;
  logic [7:0] rdata;
  logic [2:0] level;

  logic       f_flush, f_wreq, f_rreq, f_clr_err;
  logic [7:0] f_wdata;
  logic       f_wfull, f_almost_full, f_rvalid, f_rempty, f_almost_empty;
  logic       f_overflow, f_underflow;
  logic [7:0] f_rdata;
  logic [2:0] f_level;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_sync_flags #(
    .DATA_WIDTH(8), .DEPTH_WIDTH(2), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1), .FWFT(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .wreq(wreq), .wdata(wdata),
    .wfull(wfull), .almost_full(almost_full), .rreq(rreq), .rdata(rdata),
    .rvalid(rvalid), .rempty(rempty), .almost_empty(almost_empty), .level(level),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  fifo_sync_flags #(
    .DATA_WIDTH(8), .DEPTH_WIDTH(2), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1), .FWFT(1'b1)
  ) dut_f (
    .clk(clk), .rst(rst), .flush(f_flush), .wreq(f_wreq), .wdata(f_wdata),
    .wfull(f_wfull), .almost_full(f_almost_full), .rreq(f_rreq), .rdata(f_rdata),
    .rvalid(f_rvalid), .rempty(f_rempty), .almost_empty(f_almost_empty),
    .level(f_level), .overflow(f_overflow), .underflow(f_underflow),
    .clr_err(f_clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush = 0; wreq = 0; rreq = 0; clr_err = 0; wdata = 8'h00;
    f_flush = 0; f_wreq = 0; f_rreq = 0; f_clr_err = 0; f_wdata = 8'h00;
    #12;
    chk("rst_level", level, 0);
    chk("rst_rempty", rempty, 1);
    chk("rst_wfull", wfull, 0);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_afull", almost_full, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    chk("rst_f_rempty", f_rempty, 1);
    rst = 1'b0;

    // 1: fill to full, then overflow
    for (int i = 0; i < 4; i++) begin
      wreq = 1; wdata = 8'(8'h11 * (i + 1));
      tick;
      chk("fill_level", level, i + 1);
      chk("fill_aempty", almost_empty, (i + 1) <= 1);
      chk("fill_afull", almost_full, (i + 1) >= 3);
      chk("fill_wfull", wfull, (i + 1) == 4);
      chk("fill_rempty", rempty, 0);
    end
    wdata = 8'h55;
    tick;
    chk("ovf_level", level, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_wfull", wfull, 1);
    wreq = 0;

    // 2: drain, then underflow
    rreq = 1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("drain_rdata", rdata, 8'(8'h11 * (i + 1)));
      chk("drain_rvalid", rvalid, 1);
      chk("drain_level", level, 3 - i);
    end
    chk("drain_rempty", rempty, 1);
    chk("drain_unf_pre", underflow, 0);
    tick;
    chk("unf_flag", underflow, 1);
    chk("unf_rvalid", rvalid, 0);
    chk("unf_rdata", rdata, 8'h44);
    chk("unf_level", level, 0);
    rreq = 0;

    // 3: steady-state write+read at level 2 across pointer wrap
    wreq = 1; wdata = 8'h60; tick;
    wdata = 8'h61; tick;
    chk("ss_level0", level, 2);
    rreq = 1;
    for (int i = 0; i < 10; i++) begin
      wdata = 8'(8'h62 + i);
      tick;
      chk("ss_level", level, 2);
      chk("ss_rvalid", rvalid, 1);
      chk("ss_rdata", rdata, 8'(8'h60 + i));
    end
    wreq = 0; rreq = 0;
    wdata = 8'h6C; wreq = 1; tick; wreq = 0;
    chk("pre_flush_level", level, 3);

    // 4: flush beats a same-cycle write; sticky flags survive flush
    flush = 1; wreq = 1; wdata = 8'h77;
    tick;
    flush = 0; wreq = 0;
    chk("flush_level", level, 0);
    chk("flush_rempty", rempty, 1);
    chk("flush_wfull", wfull, 0);
    chk("flush_afull", almost_full, 0);
    chk("flush_aempty", almost_empty, 1);
    chk("flush_rvalid", rvalid, 0);
    chk("flush_rdata", rdata, 8'h69);
    chk("flush_ovf", overflow, 1);
    chk("flush_unf", underflow, 1);
    clr_err = 1; rreq = 1;
    tick;
    chk("clr_new_unf_wins", underflow, 1);
    chk("clr_ovf", overflow, 0);
    rreq = 0;
    tick;
    clr_err = 0;
    chk("clr_unf", underflow, 0);
    wreq = 1; wdata = 8'h88; tick; wreq = 0;
    chk("post_flush_level", level, 1);
    rreq = 1; tick; rreq = 0;
    chk("post_flush_rdata", rdata, 8'h88);
    chk("post_flush_empty", rempty, 1);
    // write into empty with same-cycle read: read rejected
    wreq = 1; rreq = 1; wdata = 8'h89;
    tick;
    wreq = 0; rreq = 0;
    chk("wr_empty_rd_level", level, 1);
    chk("wr_empty_rd_unf", underflow, 1);
    chk("wr_empty_rd_rvalid", rvalid, 0);
    clr_err = 1; tick; clr_err = 0;
    rreq = 1; tick; rreq = 0;
    chk("wr_empty_rd_data", rdata, 8'h89);
    chk("wr_empty_rd_lvl0", level, 0);

    // 5: FWFT
    f_wreq = 1; f_wdata = 8'hA5;
    tick;
    f_wreq = 0;
    chk("fwft_rempty", f_rempty, 0);
    chk("fwft_rdata", f_rdata, 8'hA5);
    chk("fwft_rvalid", f_rvalid, 1);
    chk("fwft_level", f_level, 1);
    f_rreq = 1;
    tick;
    f_rreq = 0;
    chk("fwft_pop_rempty", f_rempty, 1);
    chk("fwft_pop_rvalid", f_rvalid, 0);
    chk("fwft_pop_level", f_level, 0);
    f_wreq = 1;
    for (int i = 0; i < 4; i++) begin
      f_wdata = 8'(8'hB1 + i);
      tick;
      chk("fwft_fill_head", f_rdata, 8'hB1);
      chk("fwft_fill_level", f_level, i + 1);
    end
    chk("fwft_wfull", f_wfull, 1);
    f_wdata = 8'hBF;
    tick;
    f_wreq = 0;
    chk("fwft_ovf", f_overflow, 1);
    chk("fwft_ovf_level", f_level, 4);
    f_rreq = 1;
    for (int i = 1; i < 4; i++) begin
      tick;
      chk("fwft_drain_rdata", f_rdata, 8'(8'hB1 + i));
      chk("fwft_drain_level", f_level, 4 - i);
      chk("fwft_drain_rempty", f_rempty, 0);
    end
    tick;
    f_rreq = 0;
    chk("fwft_drain_empty", f_rempty, 1);
    chk("fwft_drain_lvl0", f_level, 0);
    chk("fwft_no_unf", f_underflow, 0);

    // 6: async reset mid-burst at level 3
    wreq = 1;
    for (int i = 0; i < 3; i++) begin
      wdata = 8'(8'h90 + i);
      tick;
    end
    chk("burst_level", level, 3);
    wdata = 8'h93;
    rst = 1;
    #2;
    chk("arst_level", level, 0);
    chk("arst_rempty", rempty, 1);
    chk("arst_afull", almost_full, 0);
    chk("arst_aempty", almost_empty, 1);
    chk("arst_rdata", rdata, 0);
    chk("arst_unf", underflow, 0);
    rst = 0;
    wdata = 8'hD0;
    tick;
    wreq = 0;
    chk("post_rst_level", level, 1);
    chk("post_rst_addr0", dut.mem[0], 8'hD0);
    rreq = 1; tick; rreq = 0;
    chk("post_rst_rdata", rdata, 8'hD0);
    chk("post_rst_rvalid", rvalid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
Parametrised single-clock FIFO, next generation of the team's synchronous FIFO. Adds an occupancy count, programmable almost-full/almost-empty flags, protected pointers that drop over/underflowing requests, sticky error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. Used as the generic buffer between streaming blocks that need back-pressure margin.

Parameters:
DATA_WIDTH, 8, word width in bits (>=1)
DEPTH_WIDTH, 5, log2 of capacity; DEPTH = 2**DEPTH_WIDTH words (>=1)
AFULL_LEVEL, DEPTH-2, almost_full asserted when level >= AFULL_LEVEL (1..DEPTH)
AEMPTY_LEVEL, 1, almost_empty asserted when level <= AEMPTY_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous clear of contents and pointers
wreq  in  1  write request
wdata  in  DATA_WIDTH  write data
wfull  out  1  FIFO holds DEPTH words
almost_full  out  1  level >= AFULL_LEVEL
rreq  in  1  read request (pop)
rdata  out  DATA_WIDTH  read data
rvalid  out  1  standard mode: rdata updated this cycle; FWFT: equals ~rempty
rempty  out  1  no word available to read
almost_empty  out  1  level <= AEMPTY_LEVEL
level  out  DEPTH_WIDTH+1  number of stored words, 0..DEPTH
overflow  out  1  sticky: write attempted while wfull
underflow  out  1  sticky: read attempted while rempty
clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (async assert, sync to clk on release): level=0, rempty=1, wfull=0, almost_empty=1, almost_full=0, rvalid=0, rdata=0, overflow=0, underflow=0, pointers=0. Memory contents not reset.
- All outputs registered; flags and level reflect state after the current edge's updates.
- Write accepted iff wreq & ~wfull (wfull sampled before the edge). Accepted: wdata stored at write pointer, pointer +1 mod DEPTH.
- Read accepted iff rreq & ~rempty. Accepted: read pointer +1 mod DEPTH.
- Write to full: dropped, overflow<=1. Read from empty: ignored, underflow<=1; rdata holds, pointers unchanged.
- Simultaneous accepted write and read: level unchanged. Write into empty FIFO with rreq same cycle: read rejected (rempty=1), underflow set.
- level: +1 on write only, -1 on read only, else unchanged; never leaves 0..DEPTH.
- wfull = (level==DEPTH); rempty: standard mode (level==0); FWFT see below.
- Standard mode (FWFT=0): on accepted read, rdata <= head word at that edge, rvalid=1 for exactly the following cycle; else rvalid=0, rdata holds last value.
- FWFT mode (FWFT=1): head word presented on rdata while rempty=0; rreq pops it, next word (if any) on rdata the cycle after. Write into empty FIFO: rempty falls one cycle after the write edge, rdata valid simultaneously. level counts all words including the presented one; capacity stays DEPTH. rvalid = ~rempty.
- Pointers carry one extra segment bit; no read and write to the same RAM address in the same cycle under the acceptance rules; bypass logic not required.
- flush (sync, priority over wreq/rreq same cycle): level=0, pointers=0, rempty=1, wfull=0, almost_empty=1, almost_full=0, rvalid=0; rdata holds; sticky flags unaffected; requests in flush cycle neither accepted nor flagged.
- clr_err clears sticky flags; a new error in the same cycle wins (flag set).
- rst asserted mid-operation: immediate return to reset values regardless of clk.

Test Plan:
DW=8, DEPTH_WIDTH=2 (DEPTH=4), AFULL_LEVEL=3, AEMPTY_LEVEL=1, FWFT=0 unless stated.
1. Reset then write 0x11,0x22,0x33,0x44 -> level 1,2,3,4; almost_empty drops at level 2, almost_full rises at 3, wfull at 4; 5th write 0x55 -> dropped, overflow=1, level=4.
2. Read 4 words -> rdata 0x11,0x22,0x33,0x44 each one cycle after rreq with rvalid=1; rempty=1 after 4th; 5th rreq -> underflow=1, rvalid=0, rdata stays 0x44.
3. Level 2, wreq&rreq for 10 cycles with incrementing data -> level stays 2, data in order, pointer wrap-around clean.
4. Level 3, flush with wreq=1 -> next cycle level=0, rempty=1, wfull=0; written word not stored; clr_err -> overflow=underflow=0.
5. FWFT=1: write 0xA5 into empty -> next cycle rempty=0, rdata=0xA5, rvalid=1; rreq -> rempty=1 following cycle.
6. Assert rst asynchronously mid-burst at level 3 -> outputs reset before next clk edge; first write after release stored at address 0.
